vel_setpoint_ctrl: RTL
======================

# vel_setpoint_ctrl

Converts debounced push-button pulses into a signed velocity setpoint for the S-curve velocity profile generator. Sits directly downstream of the per-button debouncers, one input per button, and directly upstream of the profile generator, which it feeds through a valid/ready handshake. Each accepted press steps the setpoint up or down by a fixed increment with saturation; stop forces zero.

## Interface
- `VEL_W`, 16: setpoint width, signed two's complement.
- `VEL_STEP`, 100: increment applied per up/down press; must be > 0.
- `VEL_MAX`, 1000: saturation magnitude; setpoint is clamped to [-VEL_MAX, +VEL_MAX]; must be < 2^(VEL_W-1).

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pb_up`  in  1  debounced pulse from the up button; asynchronous to `clk`; any high width.
- `pb_down`  in  1  debounced pulse from the down button; same properties.
- `pb_stop`  in  1  debounced pulse from the stop button; same properties.
- `target_vel`  out  VEL_W  setpoint offered to the generator.
- `target_valid`  out  1  `target_vel` is offered.
- `target_ready`  in  1  generator accepts when high together with valid.
- `at_limit`  out  1  internal setpoint equals +VEL_MAX or -VEL_MAX.

## Operation
- Each button input passes through a 2-FF synchronizer followed by a rising-edge detector. One press produces one event, regardless of pulse width: a pulse lasting many `clk` cycles yields exactly one event.
- Internal setpoint `sp` is signed VEL_W. It is updated once per cycle, with priority: stop, then up/down.
  - A stop event sets `sp` to 0 and ignores same-cycle up/down events.
  - Up and down events in the same cycle cancel, leaving `sp` unchanged.
  - Up alone: `sp = min(sp + VEL_STEP, VEL_MAX)`.
  - Down alone: `sp = max(sp - VEL_STEP, -VEL_MAX)`.
  - Compute the sum in VEL_W+1 bits before clamping so there is no wrap-around.
- `dirty` is set whenever an event changes `sp` from its previous value. It is cleared when `target_vel` is loaded from `sp`.
- An event that leaves `sp` unchanged does not set `dirty` and produces no new offer. Examples: up at +VEL_MAX, stop at 0, or a cancelled up/down pair.
- The FSM has two states.
  - IDLE: `target_valid`=0. If `dirty` is set, load `target_vel`<=`sp`, clear `dirty`, and go to OFFER.
  - OFFER: `target_valid`=1 and `target_vel` is held stable. On handshake (`target_valid`&&`target_ready`):
    - if `dirty`, load `target_vel`<=`sp`, clear `dirty`, and stay in OFFER, giving back-to-back offers with no bubble;
    - otherwise go to IDLE.
- Presses during OFFER coalesce. Only the latest `sp` is offered next and no intermediate values are queued.
- `target_vel` never changes while `target_valid`=1 and no handshake has occurred.

## Timing
- Reset values: `target_vel`=0, `target_valid`=0, `at_limit`=0, `sp`=0, `dirty`=0, state IDLE, synchronizer and edge registers 0.
- Reset mid-OFFER drops the offer immediately (async) and discards any pending `dirty` value.
- Latency: input rise sampled at edge k → sync output at k+1 → event registered at k+2 → `sp` updated and `dirty` set at k+3 → `target_valid`=1 with new `target_vel` at k+4.
- `at_limit` is registered from `sp` and lags `sp` by one cycle.
- `target_ready` may be high in IDLE. It has no effect there.
- If an event arrives in the same cycle as a handshake, `dirty` is set by that event and the following cycle re-offers the new value.

## Structure
- Shared package `vel_ctrl_pkg` holds:
  - the FSM state typedef (IDLE, OFFER);
  - default constants VEL_W_DEF, VEL_STEP_DEF and VEL_MAX_DEF, reused by the profile generator.
- Sub-module `pulse_edge_sync` contains the 2-FF synchronizer and rising-edge detector, with ports `clk`, `rst_n`, `async_in` and `rise`. It is instantiated three times.

## Test plan
- Reset, then one `pb_up` pulse 128 cycles wide, with `target_ready`=1 → exactly one handshake with `target_vel`=100, `target_valid` first high 4 cycles after the rise, then IDLE.
- Hold `target_ready`=0; press up 3 times → `target_vel` stays 100 while valid. Raise ready → 100 accepted, then 300 offered on the next cycle with no bubble, then IDLE.
- Press up 12 times with ready=1 → offers 100…1000 then stop; `at_limit`=1. An 11th and 12th press produce no offers.
- From `sp`=200, pulse up and down in the same cycle → no offer. Pulse stop and up in the same cycle → `sp`=0, single offer of 0.
- Press down 11 times from 0 → clamps at -1000 (0xFC18 at VEL_W=16) with no wrap to positive.
- Assert `rst_n`=0 during OFFER with `dirty` set → `target_valid` drops immediately and `target_vel`=0. After release, no offer occurs until a new press.

Source files
------------

// File: rtl/vel_ctrl_pkg.sv
// Shared types and default constants for the velocity setpoint path
// (setpoint controller and S-curve profile generator).
package vel_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } vel_state_e;

    localparam int VEL_W_DEF    = 16;
    localparam int VEL_STEP_DEF = 100;
    localparam int VEL_MAX_DEF  = 1000;

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector: one single-cycle
// `rise` per low-to-high transition of `async_in`, however long it stays high.
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/vel_setpoint_ctrl.sv
// Button-driven signed velocity setpoint with saturation, offered to the
// profile generator over valid/ready; presses during an offer coalesce.
module vel_setpoint_ctrl
    import vel_ctrl_pkg::*;
#(
    parameter int VEL_W    = VEL_W_DEF,
    parameter int VEL_STEP = VEL_STEP_DEF,
    parameter int VEL_MAX  = VEL_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pb_up,
    input  logic                    pb_down,
    input  logic                    pb_stop,
    output logic signed [VEL_W-1:0] target_vel,
    output logic                    target_valid,
    input  logic                    target_ready,
    output logic                    at_limit
);

    localparam logic signed [VEL_W:0]   STEP_X = (VEL_W+1)'(VEL_STEP);
    localparam logic signed [VEL_W:0]   MAX_X  = (VEL_W+1)'(VEL_MAX);
    localparam logic signed [VEL_W-1:0] SP_MAX = VEL_W'(VEL_MAX);
    localparam logic signed [VEL_W-1:0] SP_MIN = VEL_W'(-VEL_MAX);

    logic up_ev;
    logic dn_ev;
    logic stop_ev;

    pulse_edge_sync u_sync_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pb_up),
        .rise     (up_ev)
    );

    pulse_edge_sync u_sync_down (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pb_down),
        .rise     (dn_ev)
    );

    pulse_edge_sync u_sync_stop (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pb_stop),
        .rise     (stop_ev)
    );

    logic signed [VEL_W-1:0] sp_q, sp_d;
    logic signed [VEL_W-1:0] tv_q, tv_d;
    logic                    dirty_q, dirty_d;
    logic                    at_limit_q, at_limit_d;
    vel_state_e              state_q, state_d;

    logic signed [VEL_W:0]   sp_ext;
    logic signed [VEL_W:0]   up_sum;
    logic signed [VEL_W:0]   dn_sum;
    logic                    sp_changed;
    logic                    load;

    // One guard bit keeps the pre-clamp sum from wrapping near full scale.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        sp_ext = {sp_q[VEL_W-1], sp_q};
        up_sum = sp_ext + STEP_X;
        dn_sum = sp_ext - STEP_X;
        sp_d   = sp_q;
        if (stop_ev) begin
            sp_d = '0;
        end else if (up_ev && !dn_ev) begin
            sp_d = (up_sum > MAX_X) ? SP_MAX : VEL_W'(up_sum);
        end else if (dn_ev && !up_ev) begin
            sp_d = (dn_sum < -MAX_X) ? SP_MIN : VEL_W'(dn_sum);
        end
        sp_changed = (sp_d != sp_q);
        at_limit_d = (sp_q == SP_MAX) || (sp_q == SP_MIN);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    load    = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (target_ready) begin
                    if (dirty_q) load = 1'b1;
                    else         state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A change landing in the same cycle as a load must still be offered.
        dirty_d = sp_changed ? 1'b1 : (load ? 1'b0 : dirty_q);
        tv_d    = load ? sp_q : tv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q       <= '0;
            tv_q       <= '0;
            dirty_q    <= 1'b0;
            at_limit_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            sp_q       <= sp_d;
            tv_q       <= tv_d;
            dirty_q    <= dirty_d;
            at_limit_q <= at_limit_d;
            state_q    <= state_d;
        end
    end

    assign target_vel   = tv_q;
    assign target_valid = (state_q == ST_OFFER);
    assign at_limit     = at_limit_q;

endmodule
